// File: rtl/music_fx_pkg.sv
// Shared constants and helpers for the music effects engine.
// clamp_oct limits a signed octave request to +/-oct_max.
// shift_hp applies an octave shift to a half-period. Downward shifts saturate
// to the all-ones value of the target width. Upward shifts never turn a
// non-zero note into silence.
package music_fx_pkg;

    localparam int OCT_W           = 3;
    localparam int OCT_MAX_DEFAULT = 2;

    function automatic logic signed [OCT_W-1:0] clamp_oct(
        input logic signed [OCT_W-1:0] oct,
        input int                      oct_max
    );
        int v;
        v = int'(oct);
        if (v > oct_max) begin
            v = oct_max;
        end else if (v < -oct_max) begin
            v = -oct_max;
        end
        return OCT_W'(v);
    endfunction

    // hp is a zero-extended half-period of 'width' bits (width <= 32).
    // Negative oct means a lower pitch, which gives a longer half-period.
    function automatic logic [31:0] shift_hp(
        input logic [31:0]             hp,
        input logic signed [OCT_W-1:0] oct,
        input int                      width
    );
        logic [63:0] wide;
        logic [63:0] ones;
        logic [31:0] res;
        int          amt;
        amt  = int'(oct);
        ones = (64'd1 << width) - 64'd1;
        res  = hp;
        if (amt < 0) begin
            wide = {32'd0, hp} << (-amt);
            res  = (wide > ones) ? ones[31:0] : wide[31:0];
        end else if (amt > 0) begin
            res = hp >> amt;
            if (res == 32'd0 && hp != 32'd0) begin
                res = 32'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/music_fx_engine_if.sv
// Control and output bundle between the note/control register block and the
// music effects engine.
//   master: drives note_load, note_hp, oct_sel, tremolo_ena, trem_hp, led_ena
//           and observes audio_out, led_out, tone_edge
//   slave : the engine itself
interface music_fx_engine_if #(
    parameter int DIV_W  = 16,
    parameter int TREM_W = 20,
    parameter int N_LEDS = 6
);
    logic                               note_load;
    logic [DIV_W-1:0]                   note_hp;
    logic [music_fx_pkg::OCT_W-1:0]     oct_sel;
    logic                               tremolo_ena;
    logic [TREM_W-1:0]                  trem_hp;
    logic                               led_ena;
    logic                               audio_out;
    logic [N_LEDS-1:0]                  led_out;
    logic                               tone_edge;

    modport master (
        output note_load, note_hp, oct_sel, tremolo_ena, trem_hp, led_ena,
        input  audio_out, led_out, tone_edge
    );

    modport slave (
        input  note_load, note_hp, oct_sel, tremolo_ena, trem_hp, led_ena,
        output audio_out, led_out, tone_edge
    );
endinterface

// File: rtl/tone_divider.sv
// Half-period divider producing a square-wave phase.
//   clk, rst : clock and synchronous active-high reset
//   hp       : half-period in clk cycles; sampled at every phase toggle
//   hp_apply : while idle (latched hp = 0), load hp at once with phase 0
//   phase    : square-wave phase, held at 0 while idle
//   toggle   : registered pulse, high in the cycle after phase flipped
module tone_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] hp,
    input  logic         hp_apply,
    output logic         phase,
    output logic         toggle
);
    logic [W-1:0] cnt;
    logic [W-1:0] cur;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            cnt    <= '0;
            cur    <= '0;
            phase  <= 1'b0;
            toggle <= 1'b0;
        end else begin
            toggle <= 1'b0;
            if (cur == '0) begin
                if (hp_apply && hp != '0) begin
                    cur   <= hp;
                    cnt   <= hp - W'(1);
                    phase <= 1'b0;
                end
            end else if (cnt == '0) begin
                // A new half-period is only ever taken here, so no half-period is truncated.
                cur <= hp;
                cnt <= (hp == '0) ? '0 : hp - W'(1);
                if (hp == '0) begin
                    phase <= 1'b0;
                end else begin
                    phase  <= ~phase;
                    toggle <= 1'b1;
                end
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end
endmodule

// File: rtl/music_fx_engine.sv
// Music effects engine. Produces a square-wave tone with a signed octave shift,
// tremolo gating and a one-hot LED chaser locked to the tone.
//   clk, rst : clock and synchronous active-high reset
//   bus      : control inputs (note_load, note_hp, oct_sel, tremolo_ena,
//              trem_hp, led_ena) and registered outputs (audio_out, led_out)
//              plus the tone_edge pulse
module music_fx_engine
    import music_fx_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int TREM_W    = 20,
    parameter int OCT_MAX   = OCT_MAX_DEFAULT,
    parameter int N_LEDS    = 6,
    parameter int LED_PRE_W = 3
) (
    input logic               clk,
    input logic               rst,
    music_fx_engine_if.slave  bus
);
    logic [DIV_W-1:0]        pend_hp;
    logic [DIV_W-1:0]        sel_hp;
    logic [DIV_W-1:0]        hp_eff;
    logic signed [OCT_W-1:0] pend_oct;
    logic signed [OCT_W-1:0] sel_oct;
    logic                    tone_phase;
    logic                    tone_toggle;
    logic                    tone_edge_int;
    logic                    trem_phase;
    logic                    trem_toggle_unused;
    logic [LED_PRE_W-1:0]    pre_cnt;
    logic [N_LEDS-1:0]       ring;

    // A strobed note bypasses the pending registers. This lets it start at once
    // from silence, or take effect on a toggle that lands in the same cycle.
    assign sel_hp  = bus.note_load ? bus.note_hp : pend_hp;
    assign sel_oct = bus.note_load ? clamp_oct(bus.oct_sel, OCT_MAX) : pend_oct;
    assign hp_eff  = DIV_W'(shift_hp(32'(sel_hp), sel_oct, DIV_W));

    tone_divider #(.W(DIV_W)) u_tone (
        .clk      (clk),
        .rst      (rst),
        .hp       (hp_eff),
        .hp_apply (bus.note_load),
        .phase    (tone_phase),
        .toggle   (tone_toggle)
    );

    // Tremolo runs continuously. The gate is the inverted phase, so an idle
    // divider (trem_hp = 0) leaves the gate open.
    tone_divider #(.W(TREM_W)) u_trem (
        .clk      (clk),
        .rst      (rst),
        .hp       (bus.trem_hp),
        .hp_apply (1'b1),
        .phase    (trem_phase),
        .toggle   (trem_toggle_unused)
    );

    assign tone_edge_int = tone_toggle & tone_phase;
    assign bus.tone_edge = tone_edge_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_hp       <= '0;
            pend_oct      <= '0;
            pre_cnt       <= '0;
            ring          <= N_LEDS'(1);
            bus.audio_out <= 1'b0;
            bus.led_out   <= '0;
        end else begin
            if (bus.note_load) begin
                pend_hp  <= bus.note_hp;
                pend_oct <= sel_oct;
            end
            bus.audio_out <= tone_phase & (~bus.tremolo_ena | ~trem_phase);
            bus.led_out   <= bus.led_ena ? ring : '0;
            // The ring advances even when the LEDs are disabled. It freezes
            // during silence because no tone edges occur.
            if (tone_edge_int) begin
                pre_cnt <= pre_cnt + LED_PRE_W'(1);
                if (&pre_cnt) begin
                    ring <= pend_oct[OCT_W-1] ? {ring[0], ring[N_LEDS-1:1]}
                                              : {ring[N_LEDS-2:0], ring[N_LEDS-1]};
                end
            end
        end
    end
endmodule
